// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - RISC-V instruction fetch stage with IF/ID pipeline register
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        completion;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target_i[1:0];

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign completion  = imem_req_o & imem_ready_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    if (state_q == S_IDLE) begin
      if (start_i) state_d = S_FETCH;
    end else if (flush_i) begin
      pc_d         = {branch_target_i[31:2], 2'b00};
      if_instr_d   = NOP_INSTR;
      if_valid_d   = 1'b0;
      hold_pc_d    = 32'h0;
      hold_instr_d = 32'h0;
      state_d      = S_REDIRECT;
    end else if (state_q == S_REDIRECT) begin
      // The dead cycle lasts exactly one clock even under stall; IF/ID is already a bubble.
      state_d = S_FETCH;
    end else if (stall_i) begin
      if (completion) begin
        hold_pc_d    = pc_q;
        hold_instr_d = imem_data_i;
        state_d      = S_HOLD;
      end
    end else if (state_q == S_HOLD) begin
      if_pc_d      = hold_pc_q;
      if_instr_d   = hold_instr_q;
      if_valid_d   = 1'b1;
      pc_d         = pc_q + 32'd4;
      hold_pc_d    = 32'h0;
      hold_instr_d = 32'h0;
      state_d      = S_FETCH;
    end else if (completion) begin
      if_pc_d    = pc_q;
      if_instr_d = imem_data_i;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end else begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      if_pc_q      <= 32'h0;
      if_instr_q   <= NOP_INSTR;
      if_valid_q   <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign pc_o    = if_pc_q;
  assign instr_o = if_instr_q;
  assign valid_o = if_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized reference-model bench for if_id_stage
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, flush_i, imem_ready_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, imem_data_i, pc_o, instr_o;

  logic        rst2, start2, stall2, flush2, ready2;
  logic [31:0] target2;
  logic        req2, valid2;
  logic [31:0] addr2, data2, pc2, instr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'd1;
  endfunction

  assign imem_data_i = mem_fn(imem_addr_o);
  assign data2       = mem_fn(addr2);

  if_id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .imem_ready_i(imem_ready_i), .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i(clk_i), .rst_i(rst2), .start_i(start2), .stall_i(stall2),
    .flush_i(flush2), .branch_target_i(target2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_data_i(data2),
    .imem_ready_i(ready2), .pc_o(pc2), .instr_o(instr2), .valid_o(valid2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch sequencer described as activity flags plus a park queue.
  bit          m_active, m_dead;
  logic [63:0] m_park[$];
  logic [31:0] m_pc, m_out_pc, m_out_instr;
  bit          m_out_valid;

  function automatic bit m_req();
    return m_active && !m_dead && (m_park.size() == 0);
  endfunction

  task automatic model_reset();
    m_active = 0; m_dead = 0; m_park.delete();
    m_pc = 32'h0; m_out_pc = 32'h0; m_out_instr = NOP; m_out_valid = 0;
  endtask

  task automatic model_edge();
    bit done;
    logic [63:0] e;
    done = m_req() && imem_ready_i;
    if (!m_active) begin
      if (start_i) m_active = 1;
    end else if (flush_i) begin
      m_out_instr = NOP; m_out_valid = 0;
      m_park.delete();
      m_pc = branch_target_i & ~32'd3;
      m_dead = 1;
    end else if (m_dead) begin
      m_dead = 0;
    end else if (stall_i) begin
      if (done) m_park.push_back({m_pc, mem_fn(m_pc)});
    end else if (m_park.size() != 0) begin
      e = m_park.pop_front();
      m_out_pc = e[63:32]; m_out_instr = e[31:0]; m_out_valid = 1;
      m_pc = m_pc + 32'd4;
    end else if (done) begin
      m_out_pc = m_pc; m_out_instr = mem_fn(m_pc); m_out_valid = 1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_out_instr = NOP; m_out_valid = 0;
    end
  endtask

  task automatic step(input bit s, input bit st, input bit fl,
                      input logic [31:0] bt, input bit rd);
    start_i = s; stall_i = st; flush_i = fl; branch_target_i = bt; imem_ready_i = rd;
    #1;
    check("imem_req", {31'b0, imem_req_o}, {31'b0, m_req()});
    check("imem_addr", imem_addr_o, m_pc);
    @(posedge clk_i);
    model_edge();
    #1;
    check("pc_o", pc_o, m_out_pc);
    check("instr_o", instr_o, m_out_instr);
    check("valid_o", {31'b0, valid_o}, {31'b0, m_out_valid});
  endtask

  task automatic check_reset_outputs();
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_instr_o", instr_o, NOP);
    check("rst_valid_o", {31'b0, valid_o}, 32'h0);
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
  endtask

  initial begin
    rst_i = 0; start_i = 0; stall_i = 0; flush_i = 0; imem_ready_i = 0;
    branch_target_i = 0;
    rst2 = 0; start2 = 0; stall2 = 0; flush2 = 0; ready2 = 1; target2 = 0;
    model_reset();
    #12;
    check_reset_outputs();
    rst_i = 1; rst2 = 1;
    @(posedge clk_i); #1;

    // Streaming at full rate
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    // Ready every third cycle
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, (i % 3) == 2);
    // Stall across a completion, then release
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    // Flush during a completion with a misaligned target
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h0000_0043, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    // Flush together with stall while parked
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a wait
    step(0, 0, 0, 0, 0);
    #3; rst_i = 0; #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk_i); #2; rst_i = 1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        #3; rst_i = 0; #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk_i); #2; rst_i = 1;
        @(posedge clk_i); #1;
      end
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0), $urandom(), ($urandom_range(0, 1) == 1));
    end

    // Wrap-around from the top of the address space
    start2 = 1;
    @(posedge clk_i); #1;
    start2 = 0;
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);
    @(posedge clk_i); #1;
    check("wrap_pc0", pc2, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'b0, valid2}, 32'h1);
    check("wrap_addr1", addr2, 32'h0);
    @(posedge clk_i); #1;
    check("wrap_pc1", pc2, 32'h0);
    check("wrap_instr1", instr2, mem_fn(32'h0));
    check("wrap_req", {31'b0, req2}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
